// File: rtl/tmnt_audio_mixer.sv
// tmnt_audio_mixer: final TMNT sound-board mixing stage.
// On each sample_ce the source samples are captured into shadow registers.
// The five scaled terms are then summed over five cycles through a single
// shared multiplier. The sum is saturated to a signed 16-bit mono output.
module tmnt_audio_mixer #(
    parameter logic [7:0] THEME_GAIN = 8'd128,
    parameter logic [7:0] YM_GAIN    = 8'd128,
    parameter logic [7:0] UPD_GAIN   = 8'd128,
    parameter int         ACC_W      = 20
) (
    input  logic        clk_main,
    input  logic        nRESET,
    input  logic        sample_ce,
    input  logic [6:0]  pcm_a,
    input  logic [6:0]  pcm_b,
    input  logic [7:0]  levels,
    input  logic [15:0] theme_in,
    input  logic [15:0] ym_in,
    input  logic [7:0]  upd_in,
    input  logic [4:0]  mute,
    output logic [15:0] audio_out,
    output logic        out_valid,
    output logic        clip,
    output logic        overrun
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_SAT} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    state_t                  state_reg;
    logic [2:0]              idx_reg;
    logic signed [ACC_W-1:0] acc_reg;

    // Shadow copies so input changes mid-mix cannot disturb the sum
    logic [6:0]  pcm_a_reg;
    logic [6:0]  pcm_b_reg;
    logic [7:0]  levels_reg;
    logic [15:0] theme_reg;
    logic [15:0] ym_reg;
    logic [7:0]  upd_reg;
    logic [4:0]  mute_reg;

    // Offset-binary sources recentred to signed by inverting the MSB
    logic [6:0] pa_c;
    logic [6:0] pb_c;
    logic [7:0] upd_c;
    assign pa_c  = {~pcm_a_reg[6], pcm_a_reg[5:0]};
    assign pb_c  = {~pcm_b_reg[6], pcm_b_reg[5:0]};
    assign upd_c = {~upd_reg[7], upd_reg[6:0]};

    logic signed [16:0]      op_a;
    logic [7:0]              op_b;
    logic                    sh7;
    logic [7:0]              mute8;
    logic signed [25:0]      prod;
    logic signed [25:0]      term;
    logic signed [ACC_W-1:0] term_ext;

    assign mute8 = {3'b000, mute_reg};

    // Select the multiplier operands and the post-shift for the current term
    always_comb begin
        op_a = '0;
        op_b = '0;
        sh7  = 1'b0;
        case (idx_reg)
            3'd0: begin
                op_a = {pa_c[6], pa_c, 9'd0};
                op_b = {4'd0, levels_reg[3:0]};
            end
            3'd1: begin
                op_a = {pb_c[6], pb_c, 9'd0};
                op_b = {4'd0, levels_reg[7:4]};
            end
            3'd2: begin
                op_a = {theme_reg[15], theme_reg};
                op_b = THEME_GAIN;
                sh7  = 1'b1;
            end
            3'd3: begin
                op_a = {ym_reg[15], ym_reg};
                op_b = YM_GAIN;
                sh7  = 1'b1;
            end
            3'd4: begin
                op_a = {upd_c[7], upd_c, 8'd0};
                op_b = UPD_GAIN;
                sh7  = 1'b1;
            end
            default: ;
        endcase
        // Zeroing the operand makes a muted term exactly 0 after the floor shift
        if (mute8[idx_reg]) begin
            op_a = '0;
        end
    end

    // Single shared multiplier; gains and levels are unsigned
    assign prod     = op_a * $signed({1'b0, op_b});
    assign term     = sh7 ? (prod >>> 7) : (prod >>> 4);
    assign term_ext = ACC_W'(term);

    // Mix sequencer: capture, accumulate five terms, saturate and present
    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            acc_reg    <= '0;
            pcm_a_reg  <= '0;
            pcm_b_reg  <= '0;
            levels_reg <= '0;
            theme_reg  <= '0;
            ym_reg     <= '0;
            upd_reg    <= '0;
            mute_reg   <= '0;
            audio_out  <= '0;
            out_valid  <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sample_ce && state_reg != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (sample_ce) begin
                        pcm_a_reg  <= pcm_a;
                        pcm_b_reg  <= pcm_b;
                        levels_reg <= levels;
                        theme_reg  <= theme_in;
                        ym_reg     <= ym_in;
                        upd_reg    <= upd_in;
                        mute_reg   <= mute;
                        acc_reg    <= '0;
                        idx_reg    <= '0;
                        state_reg  <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_reg <= acc_reg + term_ext;
                    idx_reg <= idx_reg + 3'd1;
                    if (idx_reg == 3'd4) begin
                        state_reg <= ST_SAT;
                    end
                end
                ST_SAT: begin
                    if (acc_reg > SAT_MAX) begin
                        audio_out <= 16'h7FFF;
                        clip      <= 1'b1;
                    end else if (acc_reg < SAT_MIN) begin
                        audio_out <= 16'h8000;
                        clip      <= 1'b1;
                    end else begin
                        audio_out <= acc_reg[15:0];
                        clip      <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmnt_audio_mixer.sv
// tb_tmnt_audio_mixer: directed and random mixes checked against a reference model.
module tb_tmnt_audio_mixer;

    logic        clk_main = 1'b0;
    logic        nRESET = 1'b0;
    logic        sample_ce = 1'b0;
    logic [6:0]  pcm_a = 7'd64;
    logic [6:0]  pcm_b = 7'd64;
    logic [7:0]  levels = 8'h00;
    logic [15:0] theme_in = 16'h0000;
    logic [15:0] ym_in = 16'h0000;
    logic [7:0]  upd_in = 8'd128;
    logic [4:0]  mute = 5'b11111;
    logic [15:0] audio_out;
    logic        out_valid;
    logic        clip;
    logic        overrun;

    typedef struct packed {
        logic [15:0] aud;
        logic        cl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt = 0;

    always #5 clk_main = ~clk_main;

    tmnt_audio_mixer #(
        .THEME_GAIN(8'd128),
        .YM_GAIN   (8'd128),
        .UPD_GAIN  (8'd128),
        .ACC_W     (20)
    ) dut (
        .clk_main (clk_main),
        .nRESET   (nRESET),
        .sample_ce(sample_ce),
        .pcm_a    (pcm_a),
        .pcm_b    (pcm_b),
        .levels   (levels),
        .theme_in (theme_in),
        .ym_in    (ym_in),
        .upd_in   (upd_in),
        .mute     (mute),
        .audio_out(audio_out),
        .out_valid(out_valid),
        .clip     (clip),
        .overrun  (overrun)
    );

    // Count every clock in which out_valid is seen high
    always @(negedge clk_main) begin
        if (out_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    // Reference model built directly from the term definitions
    function automatic exp_t model(input logic [6:0] pa, input logic [6:0] pb,
                                   input logic [7:0] lv, input logic [15:0] th,
                                   input logic [15:0] ym, input logic [7:0] up,
                                   input logic [4:0] mu);
        int t0, t1, t2, t3, t4, sum, th_i, ym_i;
        exp_t e;
        th_i = $signed(th);
        ym_i = $signed(ym);
        t0 = mu[0] ? 0 : (((int'(pa) - 64) * 512 * int'(lv[3:0])) >>> 4);
        t1 = mu[1] ? 0 : (((int'(pb) - 64) * 512 * int'(lv[7:4])) >>> 4);
        t2 = mu[2] ? 0 : ((th_i * 128) >>> 7);
        t3 = mu[3] ? 0 : ((ym_i * 128) >>> 7);
        t4 = mu[4] ? 0 : (((int'(up) - 128) * 256 * 128) >>> 7);
        sum = t0 + t1 + t2 + t3 + t4;
        if (sum > 32767) begin
            e.aud = 16'h7FFF; e.cl = 1'b1;
        end else if (sum < -32768) begin
            e.aud = 16'h8000; e.cl = 1'b1;
        end else begin
            e.aud = sum[15:0]; e.cl = 1'b0;
        end
        return e;
    endfunction

    task automatic set_inputs(input logic [6:0] pa, input logic [6:0] pb,
                              input logic [7:0] lv, input logic [15:0] th,
                              input logic [15:0] ym, input logic [7:0] up,
                              input logic [4:0] mu);
        pcm_a = pa; pcm_b = pb; levels = lv; theme_in = th;
        ym_in = ym; upd_in = up; mute = mu;
    endtask

    // Push the expected result, then pulse sample_ce for one clock
    task automatic strobe(input bit expect_out);
        if (expect_out)
            exp_q.push_back(model(pcm_a, pcm_b, levels, theme_in, ym_in, upd_in, mute));
        sample_ce = 1'b1;
        @(posedge clk_main);
        #1 sample_ce = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts clocks from the strobe edge
    task automatic wait_valid(output int lat, output bit got);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_main);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
    endtask

    task automatic test_reset;
        nRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_main) sample_ce = ~sample_ce;
        end
        sample_ce = 1'b0;
        @(negedge clk_main);
        n_checks++;
        if ({audio_out, out_valid, clip, overrun} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset: got audio=%h valid=%b clip=%b ovr=%b, expected all 0",
                     audio_out, out_valid, clip, overrun);
        end
        n_checks++;
        if (pulse_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %0d out_valid pulses, expected 0", pulse_cnt);
        end
        nRESET = 1'b1;
        @(posedge clk_main); #1;
        $display("test_reset: audio=%h valid=%b clip=%b overrun=%b", audio_out, out_valid, clip, overrun);
    endtask

    // One mix that is compared against the scoreboard head, with latency check
    task automatic test_one(input string name);
        int lat; bit got; exp_t e;
        strobe(1'b1);
        // scramble live inputs: shadow regs must isolate the mix in progress
        set_inputs(7'($urandom), 7'($urandom), 8'($urandom), 16'($urandom),
                   16'($urandom), 8'($urandom), 5'($urandom));
        wait_valid(lat, got);
        n_checks++;
        if (!got || lat != 7) begin
            n_fail++;
            $display("FAIL %s_latency: got=%0b lat=%0d, expected out_valid at 7", name, got, lat);
        end
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue, expected an entry", name);
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (got && (audio_out !== e.aud || clip !== e.cl)) begin
            n_fail++;
            $display("FAIL %s_data: got audio=%0d clip=%b, expected audio=%0d clip=%b",
                     name, $signed(audio_out), clip, $signed(e.aud), e.cl);
        end
        @(negedge clk_main);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: got out_valid=%b one clk later, expected 0", name, out_valid);
        end
        $display("%s: audio=%0d clip=%b lat=%0d", name, $signed(audio_out), clip, lat);
    endtask

    task automatic test_pcm_a;
        set_inputs(7'd127, 7'd64, 8'h0F, 16'h0, 16'h0, 8'd128, 5'b11110);
        n_checks++;
        if (model(pcm_a, pcm_b, levels, theme_in, ym_in, upd_in, mute) !== {16'd30240, 1'b0}) begin
            n_fail++;
            $display("FAIL pcm_a_model: expected 30240 clip 0 from reference model");
        end
        test_one("test_pcm_a");
    endtask

    task automatic test_saturate_neg;
        set_inputs(7'd0, 7'd0, 8'hFF, 16'h0, 16'h0, 8'd128, 5'b11100);
        test_one("test_saturate_neg");
        n_checks++;
        if (audio_out !== 16'h8000 || clip !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg_const: got %h clip=%b, expected 8000 clip=1", audio_out, clip);
        end
    endtask

    task automatic test_theme_ym;
        set_inputs(7'd64, 7'd64, 8'h00, 16'h4000, 16'h4000, 8'd128, 5'b10011);
        test_one("test_theme_ym_sat");
        n_checks++;
        if (audio_out !== 16'h7FFF || clip !== 1'b1) begin
            n_fail++;
            $display("FAIL theme_ym_sat: got %h clip=%b, expected 7fff clip=1", audio_out, clip);
        end
        set_inputs(7'd64, 7'd64, 8'h00, 16'h2000, 16'h4000, 8'd128, 5'b10011);
        test_one("test_theme_ym");
        n_checks++;
        if (audio_out !== 16'd24576 || clip !== 1'b0) begin
            n_fail++;
            $display("FAIL theme_ym: got %0d clip=%b, expected 24576 clip=0", audio_out, clip);
        end
    endtask

    // Strobes exactly 7 clocks apart must all be accepted
    task automatic test_back_to_back;
        int lat; bit got; exp_t e;
        set_inputs(7'd100, 7'd20, 8'h5A, 16'h1234, 16'hF000, 8'd200, 5'b00000);
        strobe(1'b1);
        for (int k = 0; k < 4; k++) begin
            set_inputs(7'($urandom), 7'($urandom), 8'($urandom), 16'($urandom),
                       16'($urandom), 8'($urandom), 5'($urandom));
            wait_valid(lat, got);
            if (k < 3) begin
                exp_q.push_back(model(pcm_a, pcm_b, levels, theme_in, ym_in, upd_in, mute));
                sample_ce = 1'b1;
            end
            n_checks++;
            if (!got || lat != 7 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got=%0b lat=%0d, expected 7", k, got, lat);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (audio_out !== e.aud || clip !== e.cl) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %0d/%b, expected %0d/%b",
                             k, $signed(audio_out), clip, $signed(e.aud), e.cl);
                end
            end
            $display("test_back_to_back[%0d]: audio=%0d clip=%b", k, $signed(audio_out), clip);
            if (k < 3) begin
                @(posedge clk_main);
                #1 sample_ce = 1'b0;
            end
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overrun: got %b, expected 0", overrun);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            set_inputs(7'($urandom), 7'($urandom), 8'($urandom), 16'($urandom),
                       16'($urandom), 8'($urandom), 5'($urandom_range(0, 31)));
            test_one("test_random");
        end
    endtask

    task automatic test_overrun;
        int lat; bit got; int p0;
        set_inputs(7'd64, 7'd64, 8'hFF, 16'h0, 16'h0, 8'd128, 5'b00000);
        p0 = pulse_cnt;
        strobe(1'b0);
        @(posedge clk_main); @(posedge clk_main);
        #1 sample_ce = 1'b1;
        @(posedge clk_main);
        #1 sample_ce = 1'b0;
        wait_valid(lat, got);
        n_checks++;
        if (!got || lat != 4 || audio_out !== 16'd0 || clip !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_mix: got=%0b lat=%0d audio=%0d clip=%b, expected lat 4 audio 0",
                     got, lat, $signed(audio_out), clip);
        end
        repeat (12) @(negedge clk_main);
        n_checks++;
        if (pulse_cnt - p0 != 1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun: got pulses=%0d ovr=%b, expected 1 pulse ovr=1",
                     pulse_cnt - p0, overrun);
        end
        set_inputs(7'd10, 7'd64, 8'h07, 16'h0, 16'h0, 8'd128, 5'b11110);
        test_one("test_overrun_after");
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b, expected 1", overrun);
        end
        $display("test_overrun: overrun=%b", overrun);
    endtask

    task automatic test_reset_midmix;
        int p0;
        set_inputs(7'd127, 7'd127, 8'hFF, 16'h7000, 16'h7000, 8'd255, 5'b00000);
        p0 = pulse_cnt;
        strobe(1'b0);
        @(posedge clk_main); @(posedge clk_main);
        #1 nRESET = 1'b0;
        @(negedge clk_main);
        n_checks++;
        if ({audio_out, out_valid, clip, overrun} !== 19'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got audio=%h v=%b c=%b o=%b, expected all 0",
                     audio_out, out_valid, clip, overrun);
        end
        @(posedge clk_main); @(posedge clk_main);
        #1 nRESET = 1'b1;
        repeat (12) @(negedge clk_main);
        n_checks++;
        if (pulse_cnt != p0 || audio_out !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_abort: got pulses=%0d audio=%0d, expected 0 and 0",
                     pulse_cnt - p0, $signed(audio_out));
        end
        $display("test_reset_midmix: pulses=%0d audio=%0d", pulse_cnt - p0, $signed(audio_out));
        set_inputs(7'd90, 7'd30, 8'h93, 16'hE000, 16'h0100, 8'd40, 5'b00000);
        test_one("test_after_reset");
    endtask

    initial begin
        test_reset();
        test_pcm_a();
        test_saturate_neg();
        test_theme_ym();
        test_back_to_back();
        test_random();
        test_overrun();
        test_reset_midmix();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
